alu_share_arbiter: RTL and testbench

//  Shares one prv32 ALU instance between two requesters (port 0: EX-stage

---
 rtl/alu_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters.
// Registered issue, captured result, valid/ready response.
module alu_share_arbiter #(
  parameter int XLEN    = 32,
  parameter int FN_W    = 4,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [XLEN-1:0]    req0_a,
  input  logic [XLEN-1:0]    req0_b,
  input  logic [FN_W-1:0]    req0_alufn,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [XLEN-1:0]    req1_a,
  input  logic [XLEN-1:0]    req1_b,
  input  logic [FN_W-1:0]    req1_alufn,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [FN_W-1:0]    alu_alufn,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [XLEN-1:0]    alu_r,
  input  logic [3:0]         alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [XLEN-1:0]    rsp_r,
  output logic [3:0]         rsp_flags,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [FN_W-1:0]    fn;
    logic [SHAMT_W-1:0] shamt;
  } op_t;

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;
  op_t    op_q, op_d;
  logic   id_q, id_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_r_q, rsp_r_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;

  logic accept;
  logic grant0;
  logic grant1;
  logic take;
  op_t  op0;
  op_t  op1;
  op_t  win;

  assign op0 = '{a: req0_a, b: req0_b,
                 fn: req0_alufn,
                 shamt: req0_shamt};
  assign op1 = '{a: req1_a, b: req1_b,
                 fn: req1_alufn,
                 shamt: req1_shamt};

  assign accept = (state_q == IDLE) ||
                  ((state_q == RESP) && rsp_ready);

  // Contention resolved by the pointer; a lone request always wins.
  assign grant0 = req0_valid &&
                  (!req1_valid || !ptr_q);
  assign grant1 = req1_valid &&
                  (!req0_valid || ptr_q);

  assign take = accept && (grant0 || grant1);
  assign win  = grant1 ? op1 : op0;

  assign req0_ready = accept && grant0;
  assign req1_ready = accept && grant1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;

    unique case (state_q)
      IDLE: begin
        if (take) state_d = ISSUE;
      end
      ISSUE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_r_d     = alu_r;
        rsp_flags_d = alu_flags;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = take ? ISSUE : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Next contention favours the port just passed over.
    if (take) begin
      op_d  = win;
      id_d  = grant1;
      ptr_d = ~grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign alu_a     = op_q.a;
  assign alu_b     = op_q.b;
  assign alu_alufn = op_q.fn;
  assign alu_shamt = op_q.shamt;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter.
// Small ALU stand-in; cycle table plus corner sequences.
module tb_alu_share_arbiter;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_SLL = 4'd2;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_alufn, req1_alufn;
  logic [5:0]  req0_shamt, req1_shamt;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_alufn, alu_flags;
  logic [5:0]  alu_shamt;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_r;
  logic [3:0]  rsp_flags;
  logic        busy;

  int n_vec;
  int n_err;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_alufn(req0_alufn),
    .req0_shamt(req0_shamt),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_alufn(req1_alufn),
    .req1_shamt(req1_shamt),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_alufn(alu_alufn),
    .alu_shamt(alu_shamt),
    .alu_r(alu_r), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: flags are {cf,zf,vf,sf}
  logic [32:0] sum33, dif33;
  logic [4:0]  amt;
  logic        cf, vf;
  always_comb begin
    sum33 = {1'b0, alu_a} + {1'b0, alu_b};
    dif33 = {1'b0, alu_a} - {1'b0, alu_b};
    amt   = (alu_shamt == 6'd32) ?
            alu_b[4:0] : alu_shamt[4:0];
    alu_r = '0;
    cf    = 1'b0;
    vf    = 1'b0;
    case (alu_alufn)
      F_ADD: begin
        alu_r = sum33[31:0];
        cf    = sum33[32];
        vf    = (alu_a[31] == alu_b[31]) &&
                (alu_r[31] != alu_a[31]);
      end
      F_SUB: begin
        alu_r = dif33[31:0];
        cf    = dif33[32];
        vf    = (alu_a[31] != alu_b[31]) &&
                (alu_r[31] != alu_a[31]);
      end
      F_SLL: alu_r = alu_a << amt;
      default: alu_r = '0;
    endcase
    alu_flags = {cf, (alu_r == 32'd0),
                 vf, alu_r[31]};
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [3:0]  fn0;
    logic [31:0] a0, b0;
    logic [3:0]  fn1;
    logic [31:0] a1, b1;
    logic        rr;
    logic        e_rdy0, e_rdy1, e_rv;
    logic        e_id;
    logic [31:0] e_r;
    logic [3:0]  e_fl;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic v0, input logic v1,
    input logic [3:0] fn0,
    input logic [31:0] a0, input logic [31:0] b0,
    input logic [3:0] fn1,
    input logic [31:0] a1, input logic [31:0] b1,
    input logic rr,
    input logic e_rdy0, input logic e_rdy1,
    input logic e_rv, input logic e_id,
    input logic [31:0] e_r, input logic [3:0] e_fl,
    input logic e_busy);
    vec_t t;
    t.v0 = v0; t.v1 = v1;
    t.fn0 = fn0; t.a0 = a0; t.b0 = b0;
    t.fn1 = fn1; t.a1 = a1; t.b1 = b1;
    t.rr = rr;
    t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1;
    t.e_rv = e_rv; t.e_id = e_id;
    t.e_r = e_r; t.e_fl = e_fl;
    t.e_busy = e_busy;
    return t;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_alufn = 0;
    req1_a = 0; req1_b = 0; req1_alufn = 0;
    req0_shamt = 0; req1_shamt = 0;
    rsp_ready = 1'b1;

    // ADD 5+7 alone, then both ports contending
    tbl.push_back(mk(1,0, F_ADD,5,7, F_ADD,0,0, 1,
                     1,0,0,0,0,4'h0,0));
    tbl.push_back(mk(0,0, F_ADD,5,7, F_ADD,0,0, 1,
                     0,0,0,0,0,4'h0,1));
    tbl.push_back(mk(0,0, F_ADD,5,7, F_ADD,0,0, 1,
                     0,0,1,0,12,4'h0,1));
    tbl.push_back(mk(0,0, F_ADD,5,7, F_ADD,0,0, 1,
                     0,0,0,0,0,4'h0,0));
    tbl.push_back(mk(1,1, F_SUB,3,3, F_SUB,9,4, 1,
                     0,1,0,0,0,4'h0,0));
    tbl.push_back(mk(1,1, F_SUB,3,3, F_SUB,9,4, 1,
                     0,0,0,0,0,4'h0,1));
    tbl.push_back(mk(1,1, F_SUB,3,3, F_SUB,9,4, 1,
                     1,0,1,1,5,4'h0,1));
    tbl.push_back(mk(1,1, F_SUB,3,3, F_SUB,9,4, 1,
                     0,0,0,0,0,4'h0,1));
    tbl.push_back(mk(1,1, F_SUB,3,3, F_SUB,9,4, 1,
                     0,1,1,0,0,4'h4,1));
    tbl.push_back(mk(1,1, F_SUB,3,3, F_SUB,9,4, 1,
                     0,0,0,0,0,4'h0,1));
    tbl.push_back(mk(0,0, F_SUB,3,3, F_SUB,9,4, 1,
                     0,0,1,1,5,4'h0,1));
    tbl.push_back(mk(0,0, F_SUB,3,3, F_SUB,9,4, 1,
                     0,0,0,0,0,4'h0,0));

    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_r", rsp_r, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      req0_alufn = tbl[i].fn0;
      req0_a = tbl[i].a0; req0_b = tbl[i].b0;
      req1_alufn = tbl[i].fn1;
      req1_a = tbl[i].a1; req1_b = tbl[i].b1;
      req0_shamt = 0; req1_shamt = 0;
      rsp_ready = tbl[i].rr;
      #1;
      chk($sformatf("v%0d_rdy0", i),
          req0_ready, tbl[i].e_rdy0);
      chk($sformatf("v%0d_rdy1", i),
          req1_ready, tbl[i].e_rdy1);
      chk($sformatf("v%0d_rv", i),
          rsp_valid, tbl[i].e_rv);
      chk($sformatf("v%0d_busy", i),
          busy, tbl[i].e_busy);
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d_id", i),
            rsp_id, tbl[i].e_id);
        chk($sformatf("v%0d_r", i),
            rsp_r, tbl[i].e_r);
        chk($sformatf("v%0d_fl", i),
            rsp_flags, tbl[i].e_fl);
      end
    end

    // Back-pressure: response held for 5 cycles
    @(negedge clk);
    req0_valid = 1; req0_alufn = F_ADD;
    req0_a = 10; req0_b = 20;
    req1_valid = 0; rsp_ready = 0;
    #1 chk("bp_acc0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    req1_valid = 1; req1_alufn = F_SUB;
    req1_a = 9; req1_b = 4;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("bp_rv", rsp_valid, 1);
      chk("bp_r", rsp_r, 30);
      chk("bp_id", rsp_id, 0);
      chk("bp_fl", rsp_flags, 4'h0);
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_rdy1", req1_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1;
    #1;
    chk("bp_rel_rdy1", req1_ready, 1);
    chk("bp_rel_rv", rsp_valid, 1);
    @(negedge clk);
    req1_valid = 0;
    #1;
    chk("bp_iss_rv", rsp_valid, 0);
    chk("bp_iss_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("bp_r2_rv", rsp_valid, 1);
    chk("bp_r2_id", rsp_id, 1);
    chk("bp_r2_r", rsp_r, 5);
    @(negedge clk);
    #1 chk("bp_idle", busy, 0);

    // Async reset during ISSUE
    @(negedge clk);
    req0_valid = 1; req0_alufn = F_ADD;
    req0_a = 5; req0_b = 7;
    #1 chk("ar_acc", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    #1 chk("ar_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy0", busy, 0);
    chk("ar_rv0", rsp_valid, 0);
    chk("ar_alu_a0", alu_a, 0);
    @(negedge clk);
    #1 chk("ar_norep", rsp_valid, 0);
    rst_n = 1'b1;
    req0_valid = 1; req0_alufn = F_ADD;
    req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_alufn = F_SUB;
    req1_a = 9; req1_b = 4;
    #1;
    chk("ar_g0", req0_ready, 1);
    chk("ar_g1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    #1;
    chk("ar_rv", rsp_valid, 1);
    chk("ar_id", rsp_id, 0);
    chk("ar_r", rsp_r, 2);

    // SLL with shift amount taken from b
    @(negedge clk);
    req1_valid = 1; req1_alufn = F_SLL;
    req1_a = 1; req1_b = 4; req1_shamt = 6'd32;
    #1;
    chk("sll_rdy1", req1_ready, 1);
    chk("sll_rdy0", req0_ready, 0);
    @(negedge clk);
    req1_valid = 0;
    #1;
    chk("sll_shamt", alu_shamt, 32);
    chk("sll_b", alu_b, 4);
    chk("sll_a", alu_a, 1);
    chk("sll_fn", alu_alufn, F_SLL);
    @(negedge clk);
    #1;
    chk("sll_rv", rsp_valid, 1);
    chk("sll_id", rsp_id, 1);
    chk("sll_r", rsp_r, 16);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
